// File: rtl/exbus_pkg.sv
// Shared exbus definitions: word width and arbiter state encodings.
package exbus_pkg;

  localparam int WORD_W = 35;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWN_A = 2'b01,
    OWN_B = 2'b10
  } arb_state_t;

endpackage

// File: rtl/exarbiter_if.sv
// Stream bundle for the two-requester exbus arbiter: requesters A and B in,
// merged stream out, plus the stall-abort pulse.
interface exarbiter_if;
  import exbus_pkg::*;

  logic  i_a_stb;
  word_t i_a_word;
  logic  i_a_last;
  logic  o_a_busy;

  logic  i_b_stb;
  word_t i_b_word;
  logic  i_b_last;
  logic  o_b_busy;

  logic  o_stb;
  word_t o_word;
  logic  o_last;
  logic  i_busy;

  logic  o_abort;

  // Arbiter side
  modport slave (
    input  i_a_stb, i_a_word, i_a_last,
    input  i_b_stb, i_b_word, i_b_last,
    input  i_busy,
    output o_a_busy, o_b_busy,
    output o_stb, o_word, o_last, o_abort
  );

  // Requester / downstream side
  modport master (
    output i_a_stb, i_a_word, i_a_last,
    output i_b_stb, i_b_word, i_b_last,
    output i_busy,
    input  o_a_busy, o_b_busy,
    input  o_stb, o_word, o_last, o_abort
  );

endinterface

// File: rtl/exarb_stall.sv
// Mid-packet stall counter. timeout fires in the cycle the counter would
// step onto all-ones; the counter then restarts from zero.
module exarb_stall #(
  parameter int LGSTALL = 10
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic clear,
  input  logic count,
  output logic timeout
);

  localparam logic [LGSTALL-1:0] NEAR_FULL = ~LGSTALL'(1);

  logic [LGSTALL-1:0] cnt_reg = '0;

  assign timeout = count && !clear && (cnt_reg == NEAR_FULL);

  // Count idle cycles of the owner; any clear or a timeout restarts at zero
  always_ff @(posedge i_clk) begin
    if (i_reset || clear || timeout)
      cnt_reg <= '0;
    else if (count)
      cnt_reg <= cnt_reg + 1'b1;
  end

endmodule

// File: rtl/exarbiter.sv
// Two-way packet arbiter merging the command-response stream (A) and the
// console/debug stream (B) into one registered output stream. A grant is held
// for the whole packet and revoked if the owner stalls too long.
module exarbiter
  import exbus_pkg::*;
#(
  parameter int   LGSTALL      = 10,
  parameter logic OPT_LOWPOWER = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_reset,
  exarbiter_if.slave  bus
);

  arb_state_t state_reg = IDLE;
  arb_state_t state_next;
  logic       prio_reg  = 1'b0;
  logic       prio_next;

  logic  stb_reg  = 1'b0;
  word_t word_reg = '0;
  logic  last_reg = 1'b0;

  logic  sel_a, sel_b;
  logic  out_ready;
  logic  a_accept, b_accept, accept;
  logic  stall_clear, stall_count, timeout;
  word_t word_in;
  logic  last_in;

  // Pick the requester that may talk this cycle: the owner, or in IDLE the
  // sole requester / the one favoured by prio
  always_comb begin
    sel_a = 1'b0;
    sel_b = 1'b0;
    case (state_reg)
      OWN_A:   sel_a = 1'b1;
      OWN_B:   sel_b = 1'b1;
      default: begin
        sel_a = bus.i_a_stb && (!bus.i_b_stb || !prio_reg);
        sel_b = bus.i_b_stb && (!bus.i_a_stb ||  prio_reg);
      end
    endcase
  end

  assign out_ready = !stb_reg || !bus.i_busy;
  assign a_accept  = sel_a && bus.i_a_stb && out_ready;
  assign b_accept  = sel_b && bus.i_b_stb && out_ready;
  assign accept    = a_accept || b_accept;

  assign word_in = sel_b ? bus.i_b_word : bus.i_a_word;
  assign last_in = sel_b ? bus.i_b_last : bus.i_a_last;

  assign bus.o_a_busy = sel_a ? (stb_reg && bus.i_busy) : 1'b1;
  assign bus.o_b_busy = sel_b ? (stb_reg && bus.i_busy) : 1'b1;

  // Stall counter only runs while a packet owns the output and is silent
  assign stall_clear = (state_reg == IDLE) || accept;
  assign stall_count = (state_reg != IDLE) && !accept;

  exarb_stall #(
    .LGSTALL (LGSTALL)
  ) u_stall (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .clear   (stall_clear),
    .count   (stall_count),
    .timeout (timeout)
  );

  // A reset mid-packet drops the grant silently, so the pulse is masked
  assign bus.o_abort = timeout && !i_reset;

  // Grant FSM: single-word packets never take ownership; completion or a
  // stall timeout hands priority to the other requester
  always_comb begin
    state_next = state_reg;
    prio_next  = prio_reg;
    case (state_reg)
      IDLE: begin
        if (a_accept) begin
          if (bus.i_a_last) prio_next  = 1'b1;
          else              state_next = OWN_A;
        end else if (b_accept) begin
          if (bus.i_b_last) prio_next  = 1'b0;
          else              state_next = OWN_B;
        end
      end
      OWN_A: begin
        if ((a_accept && bus.i_a_last) || timeout) begin
          state_next = IDLE;
          prio_next  = 1'b1;
        end
      end
      OWN_B: begin
        if ((b_accept && bus.i_b_last) || timeout) begin
          state_next = IDLE;
          prio_next  = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM and priority registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg <= IDLE;
      prio_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      prio_reg  <= prio_next;
    end
  end

  // Output register: load on accept, drop stb once downstream takes the word
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      stb_reg  <= 1'b0;
      word_reg <= '0;
      last_reg <= 1'b0;
    end else if (accept) begin
      stb_reg  <= 1'b1;
      word_reg <= word_in;
      last_reg <= last_in;
    end else if (!bus.i_busy) begin
      stb_reg <= 1'b0;
      if (OPT_LOWPOWER) begin
        word_reg <= '0;
        last_reg <= 1'b0;
      end
    end
  end

  assign bus.o_stb  = stb_reg;
  assign bus.o_word = word_reg;
  assign bus.o_last = last_reg;

endmodule
